game_timer_bcd: RTL and testbench

Parametrised BCD game-clock for the Tetris play-field HUD. It generates its own one-second tick from `clk` and keeps MM…M:SS time in packed BCD. It counts up (elapsed play time) or down (timed mode) and supports pause/resume without losing the partial second, preload, saturation and expiry flags. Its output drives the seven-segment/VGA score-time renderer directly.

---
 rtl/game_timer_bcd.sv | 177 +++++++++++++++++
 tb/tb_game_timer_bcd.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_timer_bcd.sv
// Purpose: BCD game clock (MM..M:SS) with count-up/down, pause, preload, saturation and expiry flags.
// Latency: start/load act on the next edge; a time update lands TICK_DIV RUN cycles after start.
// Backpressure: none; the timer free-runs off its own divider and pause holds it.
module game_timer_bcd #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_DIGITS = 2,
    localparam int W         = 8 + 4 * MIN_DIGITS
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         pause,
    input  logic         count_down,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] time_bcd,
    output logic         running,
    output logic         done,
    output logic         saturated,
    output logic         expired,
    output logic         sec_pulse
);

    localparam int NDIG = 2 + MIN_DIGITS;
    localparam int CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(TICK_DIV - 1);

    // Sec-tens rolls at 5, every other digit at 9.
    function automatic logic [3:0] dig_max(input int i);
        return (i == 1) ? 4'd5 : 4'd9;
    endfunction

    // Pull any out-of-range digit down to its largest legal value.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > dig_max(i)) r[4*i +: 4] = dig_max(i);
        end
        return r;
    endfunction

    // Whole-word increment with a carry rippling through every digit.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (c) begin
                if (v[4*i +: 4] == dig_max(i)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Whole-word decrement, borrowing into each digit's maximum.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = dig_max(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_VAL = clamp_bcd('1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    state_t        state;
    logic [CW-1:0] div_cnt;
    logic          down;
    logic [W-1:0]  time_inc;
    logic [W-1:0]  time_dec;

    assign time_inc = bcd_inc(time_bcd);
    assign time_dec = bcd_dec(time_bcd);

    // Timer FSM: divider, digit update and all status outputs move on one edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            div_cnt   <= '0;
            down      <= 1'b0;
            time_bcd  <= '0;
            running   <= 1'b0;
            done      <= 1'b0;
            saturated <= 1'b0;
            expired   <= 1'b0;
            sec_pulse <= 1'b0;
        end else begin
            sec_pulse <= 1'b0;
            if (load) begin
                time_bcd  <= clamp_bcd(load_value);
                div_cnt   <= '0;
                state     <= IDLE;
                running   <= 1'b0;
                done      <= 1'b0;
                saturated <= 1'b0;
                expired   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            down    <= count_down;
                            div_cnt <= '0;
                            if (count_down && time_bcd == '0) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                expired <= 1'b1;
                            end else begin
                                state   <= RUN;
                                running <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            // Divider holds so the partial second survives the pause.
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            if (!down) begin
                                if (time_bcd == MAX_VAL) begin
                                    saturated <= 1'b1;
                                    state     <= DONE;
                                    running   <= 1'b0;
                                    done      <= 1'b1;
                                end else begin
                                    time_bcd  <= time_inc;
                                    sec_pulse <= 1'b1;
                                end
                            end else begin
                                time_bcd  <= time_dec;
                                sec_pulse <= 1'b1;
                                if (time_dec == '0) begin
                                    expired <= 1'b1;
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE holds until load or reset.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_timer_bcd.sv
// Bench for game_timer_bcd with TICK_DIV=4, MIN_DIGITS=2.
// Expectations come from a seconds-count model (minutes*60+seconds) converted to BCD.
module tb_game_timer_bcd;

    localparam int TD   = 4;
    localparam int MD   = 2;
    localparam int W    = 8 + 4 * MD;
    localparam int MAXS = 99 * 60 + 59;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         count_down = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] time_bcd;
    logic         running, done, saturated, expired, sec_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    game_timer_bcd #(.TICK_DIV(TD), .MIN_DIGITS(MD)) dut (
        .clk(clk), .resetn(resetn), .start(start), .pause(pause),
        .count_down(count_down), .load(load), .load_value(load_value),
        .time_bcd(time_bcd), .running(running), .done(done),
        .saturated(saturated), .expired(expired), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int bcd_to_sec(input logic [W-1:0] b);
        int m;
        m = int'(b[15:12]) * 10 + int'(b[11:8]);
        return m * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [W-1:0] sec_to_bcd(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [W-1:0] clamp_model(input logic [W-1:0] r);
        logic [W-1:0] o;
        int d, lim;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            d   = int'(r[4*i +: 4]);
            lim = (i == 1) ? 5 : 9;
            if (d > lim) d = lim;
            o[4*i +: 4] = 4'(d);
        end
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1;
        load_value = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_start(input logic m);
        count_down = m;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        n_checks++;
        if ({time_bcd, running, done, saturated, expired, sec_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset: got t=%h r=%b d=%b s=%b e=%b p=%b want all 0",
                     time_bcd, running, done, saturated, expired, sec_pulse);
        end
    endtask

    task automatic test_count_up();
        int pulses = 0, last = 0, bad_gap = 0;
        do_start(1'b0);
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL up_running: got %b want 1", running);
        end
        for (int c = 1; c <= 61 * TD; c++) begin
            step();
            if (sec_pulse === 1'b1) begin
                pulses++;
                if (c - last != TD) bad_gap++;
                last = c;
            end
        end
        n_checks++;
        if (time_bcd !== sec_to_bcd(61)) begin
            n_fail++; $display("FAIL up_time: got %h want %h", time_bcd, sec_to_bcd(61));
        end
        n_checks++;
        if (pulses !== 61) begin
            n_fail++; $display("FAIL up_pulses: got %0d want 61", pulses);
        end
        n_checks++;
        if (bad_gap !== 0) begin
            n_fail++; $display("FAIL up_spacing: got %0d bad gaps want 0", bad_gap);
        end
    endtask

    task automatic test_cascade();
        logic [W-1:0] vals [4];
        logic [W-1:0] exp_t;
        vals[0] = 16'h0959;
        vals[1] = 16'h0059;
        vals[2] = sec_to_bcd($urandom_range(0, MAXS - 1));
        vals[3] = sec_to_bcd($urandom_range(0, MAXS - 1));
        for (int i = 0; i < 4; i++) begin
            do_load(vals[i]);
            do_start(1'b0);
            repeat (TD) step();
            exp_t = sec_to_bcd(bcd_to_sec(vals[i]) + 1);
            n_checks++;
            if (time_bcd !== exp_t || sec_pulse !== 1'b1) begin
                n_fail++;
                $display("FAIL cascade[%0d]: got t=%h p=%b want t=%h p=1", i, time_bcd, sec_pulse, exp_t);
            end
        end
    endtask

    task automatic test_saturation();
        int pulses = 0;
        do_load(16'h9959);
        do_start(1'b0);
        for (int c = 0; c < TD; c++) begin
            step();
            if (sec_pulse === 1'b1) pulses++;
        end
        n_checks++;
        if (time_bcd !== 16'h9959) begin
            n_fail++; $display("FAIL sat_time: got %h want 9959", time_bcd);
        end
        n_checks++;
        if ({saturated, done, running, expired} !== 4'b1100 || pulses !== 0) begin
            n_fail++;
            $display("FAIL sat_flags: got s=%b d=%b r=%b e=%b pulses=%0d want s=1 d=1 r=0 e=0 pulses=0",
                     saturated, done, running, expired, pulses);
        end
        // start is ignored in DONE
        do_start(1'b0);
        repeat (TD) step();
        n_checks++;
        if (done !== 1'b1 || time_bcd !== 16'h9959) begin
            n_fail++; $display("FAIL done_ignores_start: got d=%b t=%h want d=1 t=9959", done, time_bcd);
        end
    endtask

    task automatic test_count_down();
        do_load(16'h0100);
        do_start(1'b1);
        repeat (TD) step();
        n_checks++;
        if (time_bcd !== 16'h0059 || expired !== 1'b0) begin
            n_fail++; $display("FAIL down_borrow: got t=%h e=%b want t=0059 e=0", time_bcd, expired);
        end
        do_load(16'h0002);
        do_start(1'b1);
        repeat (2 * TD) step();
        n_checks++;
        if (time_bcd !== 16'h0000 || expired !== 1'b1 || done !== 1'b1) begin
            n_fail++; $display("FAIL down_expire: got t=%h e=%b d=%b want t=0000 e=1 d=1", time_bcd, expired, done);
        end
        do_load(16'h0000);
        do_start(1'b1);
        n_checks++;
        if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL down_start_zero: got d=%b e=%b r=%b want d=1 e=1 r=0", done, expired, running);
        end
    endtask

    task automatic test_pause();
        int k, v, held_bad, first;
        for (int it = 0; it < 4; it++) begin
            k = (it == 0) ? 2 : $urandom_range(0, TD - 1);
            v = $urandom_range(0, MAXS - 5);
            do_load(sec_to_bcd(v));
            do_start(1'b0);
            repeat (k) step();
            pause = 1'b1;
            held_bad = 0;
            for (int c = 0; c < 100; c++) begin
                step();
                if (time_bcd !== sec_to_bcd(v) || sec_pulse !== 1'b0 || running !== 1'b0) held_bad++;
            end
            n_checks++;
            if (held_bad !== 0) begin
                n_fail++; $display("FAIL pause_hold[%0d]: got %0d bad cycles want 0", it, held_bad);
            end
            pause = 1'b0;
            step();
            first = 0;
            for (int c = 1; c <= TD + 2; c++) begin
                step();
                if (sec_pulse === 1'b1) begin
                    first = c;
                    break;
                end
            end
            n_checks++;
            if (first !== TD - k || time_bcd !== sec_to_bcd(v + 1)) begin
                n_fail++;
                $display("FAIL pause_resume[%0d]: got update after %0d cycles t=%h want %0d t=%h",
                         it, first, time_bcd, TD - k, sec_to_bcd(v + 1));
            end
        end
    endtask

    task automatic test_random();
        int v, n, pulses, e_t, e_p;
        logic m, e_sat, e_exp, e_done;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom_range(0, 10);
                1:       v = MAXS - $urandom_range(0, 10);
                default: v = $urandom_range(0, MAXS);
            endcase
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 15);
            if (!m) begin
                e_p   = (n < MAXS - v) ? n : MAXS - v;
                e_t   = v + e_p;
                e_sat = (n > MAXS - v);
                e_exp = 1'b0;
                e_done = e_sat;
            end else begin
                e_p   = (n < v) ? n : v;
                e_t   = v - e_p;
                e_sat = 1'b0;
                e_exp = (n >= v);
                e_done = e_exp;
            end
            do_load(sec_to_bcd(v));
            do_start(m);
            pulses = 0;
            for (int c = 0; c < n * TD; c++) begin
                step();
                if (sec_pulse === 1'b1) pulses++;
            end
            n_checks++;
            if (time_bcd !== sec_to_bcd(e_t) || pulses !== e_p ||
                saturated !== e_sat || expired !== e_exp || done !== e_done || running !== !e_done) begin
                n_fail++;
                $display("FAIL random[%0d] v=%0d m=%b n=%0d: got t=%h p=%0d s=%b e=%b d=%b r=%b want t=%h p=%0d s=%b e=%b d=%b",
                         it, v, m, n, time_bcd, pulses, saturated, expired, done, running,
                         sec_to_bcd(e_t), e_p, e_sat, e_exp, e_done);
            end
        end
    endtask

    task automatic test_clamp_priority();
        logic [W-1:0] raw;
        do_load(16'hABCD);
        n_checks++;
        if (time_bcd !== 16'h9959) begin
            n_fail++; $display("FAIL clamp_abcd: got %h want 9959", time_bcd);
        end
        for (int i = 0; i < 6; i++) begin
            raw = 16'($urandom);
            do_load(raw);
            n_checks++;
            if (time_bcd !== clamp_model(raw)) begin
                n_fail++; $display("FAIL clamp_rand[%0d] raw=%h: got %h want %h", i, raw, time_bcd, clamp_model(raw));
            end
        end
        // load and start together: load wins, timer stays idle
        raw = 16'h0123;
        load = 1'b1; load_value = raw; start = 1'b1; count_down = 1'b0;
        step();
        load = 1'b0; start = 1'b0;
        repeat (TD + 1) step();
        n_checks++;
        if (running !== 1'b0 || done !== 1'b0 || time_bcd !== raw) begin
            n_fail++; $display("FAIL load_start: got r=%b d=%b t=%h want r=0 d=0 t=%h", running, done, time_bcd, raw);
        end
        // reset mid-run
        do_start(1'b0);
        repeat (TD) step();
        resetn = 1'b0;
        step();
        n_checks++;
        if ({time_bcd, running, done, saturated, expired, sec_pulse} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got t=%h r=%b d=%b s=%b e=%b p=%b want all 0",
                     time_bcd, running, done, saturated, expired, sec_pulse);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        // a start while running must not resample the mode
        do_load(16'h0010);
        do_start(1'b0);
        step();
        do_start(1'b1);
        repeat (3 * TD - 2) step();
        n_checks++;
        if (time_bcd !== sec_to_bcd(13) || running !== 1'b1) begin
            n_fail++; $display("FAIL start_in_run: got t=%h r=%b want t=%h r=1", time_bcd, running, sec_to_bcd(13));
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_cascade();
        test_saturation();
        test_count_down();
        test_pause();
        test_random();
        test_clamp_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
